mem_port_arbiter: RTL

Shares one single-ported unified instruction/data memory between the IF-stage fetch port and the MEM-stage load/store port of the five-stage RV32I pipeline. The block grants at most one outstanding transaction at a time and routes the memory response back to its owner. It generates per-port stall signals for the hazard logic and bounds fetch starvation. A watchdog terminates transactions that the memory never acknowledges.

---
 rtl/mem_port_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between the fetch and load/store ports.
// One transaction in flight; responses route to the owner; a watchdog aborts lost transactions.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        me_req,
  input  logic        me_we,
  input  logic [31:0] me_addr,
  input  logic [31:0] me_wdata,
  input  logic [3:0]  me_wstrb,
  output logic        me_gnt,
  output logic        me_rvalid,
  output logic [31:0] me_rdata,
  output logic        me_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [2:0]    starve_cnt;
  logic [TW-1:0] timer;

  logic busy, abort, window, if_wins, gnt_i, gnt_d;

  assign busy    = (state != IDLE);
  // The abort cycle is the TIMEOUT-th consecutive busy cycle with no response.
  assign abort   = ~rst & busy & ~mem_rvalid & (timer == TW'(TIMEOUT - 1));
  assign window  = ~rst & ((state == IDLE) | (busy & mem_rvalid));
  assign if_wins = if_req & ((starve_cnt == 3'(STARVE_MAX)) | ~me_req);
  assign gnt_i   = window & if_wins;
  assign gnt_d   = window & me_req & ~if_wins;

  always_comb begin
    if_gnt    = gnt_i;
    me_gnt    = gnt_d;
    mem_req   = gnt_i | gnt_d;
    mem_we    = gnt_d & me_we;
    mem_wstrb = gnt_d ? me_wstrb : 4'h0;
    mem_wdata = gnt_d ? me_wdata : 32'h0;
    mem_addr  = gnt_d ? me_addr : (gnt_i ? if_addr : 32'h0);
    if_rvalid = ~rst & (state == BUSY_I) & (mem_rvalid | abort);
    me_rvalid = ~rst & (state == BUSY_D) & (mem_rvalid | abort);
    if_rdata  = (abort && state == BUSY_I) ? 32'h0 : mem_rdata;
    me_rdata  = (abort && state == BUSY_D) ? 32'h0 : mem_rdata;
    if_stall  = ~rst & (if_req | (state == BUSY_I)) & ~if_rvalid;
    me_stall  = ~rst & (me_req | (state == BUSY_D)) & ~me_rvalid;
    bus_err   = abort;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 3'd0;
      timer      <= '0;
    end else begin
      if (gnt_i) begin
        state <= BUSY_I;
        timer <= '0;
      end else if (gnt_d) begin
        state <= BUSY_D;
        timer <= '0;
      end else if (busy && (mem_rvalid || abort)) begin
        state <= IDLE;
        timer <= '0;
      end else if (busy) begin
        timer <= timer + 1'b1;
      end
      // Count only data wins that made a waiting fetch wait longer.
      if (gnt_i || !if_req)
        starve_cnt <= 3'd0;
      else if (gnt_d && starve_cnt != 3'(STARVE_MAX))
        starve_cnt <= starve_cnt + 3'd1;
    end
  end

  // A response arriving sooner than MEM_LAT means the memory model and this block disagree.
  always_ff @(posedge clk) begin
    if (!rst && busy && mem_rvalid)
      assert (int'(timer) + 1 >= MEM_LAT);
  end
endmodule
